// File: rtl/mux_key_table_if.sv
// Lookup request/result and table-write bundle for mux_key_table.
// master = producer/consumer side, slave = the table itself.
interface mux_key_table_if #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 1
);
  localparam int IDX_W = $clog2(NR_KEY);

  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [KEY_LEN-1:0]  wr_key;
  logic [DATA_LEN-1:0] wr_data;
  logic                wr_valid;
  logic                clr;

  logic                in_valid;
  logic                in_ready;
  logic [KEY_LEN-1:0]  in_key;
  logic [DATA_LEN-1:0] default_out;

  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_data;
  logic                out_hit;
  logic [IDX_W-1:0]    out_idx;

  modport master (
    output wr_en, wr_idx, wr_key, wr_data, wr_valid, clr,
    output in_valid, in_key, default_out, out_ready,
    input  in_ready, out_valid, out_data, out_hit, out_idx
  );

  modport slave (
    input  wr_en, wr_idx, wr_key, wr_data, wr_valid, clr,
    input  in_valid, in_key, default_out, out_ready,
    output in_ready, out_valid, out_data, out_hit, out_idx
  );
endinterface

// File: rtl/mux_key_table.sv
// Runtime-writable key/data table looked up through one valid/ready stage: 1-cycle latency,
// in_ready = !out_valid || out_ready (stalled results hold). MUX_KEY_TABLE_ORMERGE_EN: OR-merge multi-match data.
module mux_key_table #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 1
) (
  input  logic           clk,
  input  logic           rst,
  mux_key_table_if.slave bus
);
  localparam int IDX_W = $clog2(NR_KEY);

  typedef struct packed {
    logic                v;
    logic [KEY_LEN-1:0]  key;
    logic [DATA_LEN-1:0] data;
  } entry_t;

  entry_t              tbl [NR_KEY];

  logic                out_valid_q;
  logic [DATA_LEN-1:0] out_data_q;
  logic                out_hit_q;
  logic [IDX_W-1:0]    out_idx_q;

  logic                accept;
  logic                wr_in_range;
  logic                hit;
  logic [IDX_W-1:0]    idx;
  logic [DATA_LEN-1:0] data;

  assign bus.in_ready  = rst || !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready && !rst;
  assign wr_in_range   = ({1'b0, bus.wr_idx} < (IDX_W+1)'(NR_KEY));

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_hit   = out_hit_q;
  assign bus.out_idx   = out_idx_q;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef MUX_KEY_TABLE_ORMERGE_EN
    data = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (tbl[i].v && (tbl[i].key == bus.in_key)) begin
        hit  = 1'b1;
        idx  = IDX_W'(i);
        data = data | tbl[i].data;
      end
    end
    if (!hit) begin
      data = bus.default_out;
    end
`else
    data = bus.default_out;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (tbl[i].v && (tbl[i].key == bus.in_key)) begin
        hit  = 1'b1;
        idx  = IDX_W'(i);
        data = tbl[i].data;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_KEY; i++) begin
        tbl[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= data;
        out_hit_q   <= hit;
        out_idx_q   <= idx;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // Lookup above used the pre-edge table; clear beats a same-cycle write.
      if (bus.clr) begin
        for (int i = 0; i < NR_KEY; i++) begin
          tbl[i].v <= 1'b0;
        end
      end else if (bus.wr_en && wr_in_range) begin
        tbl[bus.wr_idx] <= '{v: bus.wr_valid, key: bus.wr_key, data: bus.wr_data};
      end
    end
  end
endmodule

// File: tb/tb_mux_key_table.sv
// Directed bench for mux_key_table (NR_KEY=4, KEY_LEN=2, DATA_LEN=4) with a per-cycle reference model.
module tb_mux_key_table;
  localparam int NK = 4;
`ifdef MUX_KEY_TABLE_ORMERGE_EN
  localparam logic [3:0] EXP_MM = 4'hF;
`else
  localparam logic [3:0] EXP_MM = 4'h3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_key_table_if #(.NR_KEY(NK), .KEY_LEN(2), .DATA_LEN(4)) bus ();

  mux_key_table #(.NR_KEY(NK), .KEY_LEN(2), .DATA_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays, list of matches, result picked from the list.
  logic       mv [NK];
  logic [1:0] mk [NK];
  logic [3:0] md [NK];
  logic       e_vld = 1'b0;
  logic [3:0] e_data = '0;
  logic       e_hit = 1'b0;
  logic [1:0] e_idx = '0;

  task automatic model_lookup(input logic [1:0] k, input logic [3:0] dflt,
                              output logic h, output logic [3:0] d, output logic [1:0] ix);
    int hits[$];
    for (int i = 0; i < NK; i++) if (mv[i] && mk[i] == k) hits.push_back(i);
    if (hits.size() == 0) begin
      h = 1'b0; d = dflt; ix = 2'd0;
    end else begin
      h = 1'b1; ix = 2'(hits[0]);
`ifdef MUX_KEY_TABLE_ORMERGE_EN
      d = 4'h0;
      foreach (hits[j]) d = d | md[hits[j]];
`else
      d = md[hits[0]];
`endif
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      e_vld = 1'b0; e_data = '0; e_hit = 1'b0; e_idx = '0;
      for (int i = 0; i < NK; i++) begin mv[i] = 1'b0; mk[i] = '0; md[i] = '0; end
    end else begin
      if (bus.in_valid && (!e_vld || bus.out_ready)) begin
        model_lookup(bus.in_key, bus.default_out, e_hit, e_data, e_idx);
        e_vld = 1'b1;
      end else if (bus.out_ready) begin
        e_vld = 1'b0;
      end
      if (bus.clr) begin
        for (int i = 0; i < NK; i++) mv[i] = 1'b0;
      end else if (bus.wr_en && int'(bus.wr_idx) < NK) begin
        mv[bus.wr_idx] = bus.wr_valid;
        mk[bus.wr_idx] = bus.wr_key;
        md[bus.wr_idx] = bus.wr_data;
      end
    end
  end

  // Compare on the falling edge, away from the active edge and the stimulus updates.
  always @(negedge clk) begin
    chk("m_in_ready", bus.in_ready, rst || !e_vld || bus.out_ready);
    chk("m_out_valid", bus.out_valid, e_vld);
    chk("m_out_data", bus.out_data, e_data);
    chk("m_out_hit", bus.out_hit, e_hit);
    chk("m_out_idx", bus.out_idx, e_idx);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input int key, input int data, input logic v);
    bus.wr_en = 1'b1; bus.wr_idx = 2'(idx); bus.wr_key = 2'(key);
    bus.wr_data = 4'(data); bus.wr_valid = v;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic res(input string nm, input int d, input int h, input int ix);
    chk({nm, "_vld"}, bus.out_valid, 1);
    chk({nm, "_data"}, bus.out_data, d);
    chk({nm, "_hit"}, bus.out_hit, h);
    chk({nm, "_idx"}, bus.out_idx, ix);
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_key = '0; bus.wr_data = '0; bus.wr_valid = 1'b0;
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_key = '0; bus.default_out = '0; bus.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // Populate keys 00..11 with data 0,1,1,0.
    wr(0, 0, 0, 1'b1); wr(1, 1, 1, 1'b1); wr(2, 2, 1, 1'b1); wr(3, 3, 0, 1'b1);

    bus.in_valid = 1'b1; bus.in_key = 2'd2; tick();
    res("lk10", 1, 1, 2);
    bus.in_key = 2'd1; tick();
    res("lk01", 1, 1, 1);
    bus.in_valid = 1'b0; tick();
    chk("drain_vld", bus.out_valid, 0);

    // Delete entry 3, then miss on key 11 returns default.
    wr(3, 3, 0, 1'b0);
    bus.in_valid = 1'b1; bus.in_key = 2'd3; bus.default_out = 4'h1; tick();
    res("miss11", 1, 0, 0);
    bus.in_valid = 1'b0; bus.default_out = 4'h0; tick();

    // Double match on key 01.
    wr(1, 1, 4'h3, 1'b1); wr(2, 1, 4'hC, 1'b1);
    bus.in_valid = 1'b1; bus.in_key = 2'd1; tick();
    res("multi", EXP_MM, 1, 1);
    bus.in_valid = 1'b0; tick();

    // Stall with a new request waiting.
    bus.in_valid = 1'b1; bus.in_key = 2'd0; tick();
    res("pre_stall", 0, 1, 0);
    bus.out_ready = 1'b0; bus.in_key = 2'd1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_in_ready", bus.in_ready, 0);
      res("stall", 0, 1, 0);
    end
    bus.out_ready = 1'b1; tick();
    res("post_stall", EXP_MM, 1, 1);
    bus.in_valid = 1'b0; tick();

    // Same-cycle rewrite of entry 0 while looking it up.
    bus.in_valid = 1'b1; bus.in_key = 2'd0;
    wr(0, 0, 1, 1'b1);
    res("rbw_old", 0, 1, 0);
    tick();
    res("rbw_new", 1, 1, 0);
    bus.in_valid = 1'b0; tick();

    // clr together with a write: everything invalid afterwards.
    bus.clr = 1'b1;
    wr(1, 1, 5, 1'b1);
    bus.clr = 1'b0;
    bus.default_out = 4'hA; bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_key = 2'(k); tick();
      res("clr_miss", 4'hA, 0, 0);
    end

    // Reset while a result is stalled.
    bus.out_ready = 1'b0; bus.in_key = 2'd0; tick(); tick();
    chk("pre_rst_vld", bus.out_valid, 1);
    rst = 1'b1; tick();
    chk("rst2_vld", bus.out_valid, 0);
    chk("rst2_data", bus.out_data, 0);
    chk("rst2_hit", bus.out_hit, 0);
    chk("rst2_idx", bus.out_idx, 0);
    chk("rst2_in_ready", bus.in_ready, 1);
    rst = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 1'b0; tick();

    bus.in_valid = 1'b1; bus.in_key = 2'd0; bus.default_out = 4'h6; tick();
    res("post_rst_miss", 4'h6, 0, 0);
    bus.in_valid = 1'b0; tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux_key_table.md
# mux_key_table

Programmable, registered successor to the combinational key-select mux: a table of `NR_KEY` runtime-writable key/data entries, each with its own valid bit, looked up through a single-stage valid/ready pipeline. A request presents a key; one cycle later the block returns the matching entry's data, a hit flag and the matching index, or `default_out` on a miss. It sits between a decode or select producer and its consumer wherever the key-to-data mapping must change at runtime rather than being wired at elaboration.

## Interface
Parameters:
- `NR_KEY`, 4, number of table entries; minimum 2
- `KEY_LEN`, 2, key width
- `DATA_LEN`, 1, data width
- `IDX_W` is a localparam, `$clog2(NR_KEY)`; it is not overridable

Ports:
- `clk` in 1: single clock, all state updates on the rising edge
- `rst` in 1: synchronous, active-high reset
- `wr_en` in 1: write one table entry this cycle
- `wr_idx` in IDX_W: entry to write; a write with `wr_idx >= NR_KEY` is ignored
- `wr_key` in KEY_LEN: key stored in the entry
- `wr_data` in DATA_LEN: data stored in the entry
- `wr_valid` in 1: valid bit stored in the entry; writing 0 deletes the entry
- `clr` in 1: invalidate all entries
- `in_valid` in 1: lookup request valid
- `in_ready` out 1: block can accept a lookup request
- `in_key` in KEY_LEN: key to look up
- `default_out` in DATA_LEN: data returned on a miss; sampled with the request
- `out_valid` out 1: lookup result valid
- `out_ready` in 1: consumer accepts the result
- `out_data` out DATA_LEN: result data
- `out_hit` out 1: 1 if at least one valid entry matched
- `out_idx` out IDX_W: index of the matching entry; 0 on a miss

## Operation
- Table storage per entry: `v`, `key`, `data`. Reset clears every field to 0.
- Write path:
  - On `wr_en` with an in-range index, the entry is loaded with `wr_valid`, `wr_key` and `wr_data` at the clock edge.
  - If `clr` and `wr_en` are asserted in the same cycle, `clr` wins and every entry, including the written one, ends invalid.
- Lookup match: an entry matches when `v` is 1 and its key equals `in_key`.
- Multiple matches: the lowest-index matching entry wins, for both `out_data` and `out_idx`.
- Miss: `out_data` is the `default_out` value sampled with the request, `out_hit` is 0 and `out_idx` is 0.
- Handshake:
  - `in_ready = !out_valid || out_ready`, so the block gives full throughput with no bubble.
  - A request is accepted when `in_valid && in_ready`; the result registers load at that edge.
  - If `out_valid && out_ready` and no new request is accepted, `out_valid` drops to 0.
  - While `out_valid && !out_ready`, `out_data`, `out_hit` and `out_idx` hold stable and `in_ready` is 0.
- Same-cycle write/clear and lookup: the lookup uses the table contents from before that edge (read-before-write). The change is visible to lookups accepted from the next cycle on.
- Table writes and `clr` never modify a result that is already registered.

## Timing
- Lookup latency is 1 cycle: a request accepted at edge N drives its result with `out_valid=1` after edge N.
- Sustained throughput is 1 lookup per cycle when `out_ready=1`.
- Reset values: `out_valid=0`, `out_data=0`, `out_hit=0`, `out_idx=0`, all entries invalid. `in_ready` reads 1 during and after reset.
- Reset mid-operation: a pending or stalled result is discarded and the table is erased, taking effect at the edge where `rst=1`. Requests presented while `rst=1` are not accepted.
- Write latency: an entry written at edge N is matchable by a request accepted at edge N+1.

## Configuration
- `MUX_KEY_TABLE_ORMERGE_EN` defined:
  - Multiple matches are resolved by OR-ing the data of all matching entries, which is the legacy key-mux semantics.
  - `out_idx` reports the lowest matching index.
- `MUX_KEY_TABLE_ORMERGE_EN` undefined (default): lowest-index priority as described under Operation.
- Hit/miss behaviour and timing are identical in both builds.

## Test plan
- After reset, write entries 0..3 with keys 00,01,10,11, data 0,1,1,0 and valid 1. Look up 10 back-to-back with 01, `out_ready=1` → results `data=1`, `hit=1`, `idx=2`, then `data=1`, `hit=1`, `idx=1` on consecutive cycles.
- Invalidate entry 3 with `wr_valid=0`, then look up 11 with `default_out=1` → `out_data=1`, `out_hit=0`, `out_idx=0`.
- DATA_LEN=4: write entry 1 {key=01, data=0x3} and entry 2 {key=01, data=0xC}, then look up 01:
  - default build → `out_data=0x3`, `out_idx=1`
  - `MUX_KEY_TABLE_ORMERGE_EN` build → `out_data=0xF`, `out_idx=1`
- Hold `out_ready=0` for 3 cycles with `in_valid=1` and a new key → `in_ready=0` and outputs frozen throughout. On `out_ready=1` the new request is accepted and its result appears the next cycle.
- Same cycle: rewrite entry 0 key 00 with data 1 (previous data 0) while looking up 00 → the result is data 0. The next lookup of 00 returns data 1.
- Assert `clr` and `wr_en` together, then pulse `rst` while `out_valid=1` and `out_ready=0`:
  - after the `clr` edge, every lookup misses
  - after the `rst` edge, all outputs are 0 and `in_ready=1`
